// File: rtl/jump_pkg.sv
// Shared types and constants for the branch/jump controller.
package jump_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_ZERO   = 2'b01,
    COND_NZERO  = 2'b10,
    COND_HALT   = 2'b11
  } cond_e;

  // IR[8:6] value that marks an instruction as a branch
  localparam logic [2:0] BR_OPCODE = 3'b111;

  // Branch target table: absolute addresses or two's-complement offsets
  localparam logic [9:0] BR_LUT [8] = '{
    10'd3, 10'd512, 10'd100, 10'h3F8,
    10'd1, 10'h3FF, 10'd0,   10'd600
  };

endpackage

// File: rtl/target_lut.sv
// Combinational branch target lookup; relative targets are corrected by -1
// because the fetch PC is already one past the branch when the redirect lands.
import jump_pkg::*;

module target_lut (
  input  logic [2:0] Idx,
  input  logic       Rel,
  output logic [9:0] Target
);

  // Table lookup with 10-bit wrapping correction for relative branches
  always_comb begin
    Target = BR_LUT[Idx];
    if (Rel) Target = BR_LUT[Idx] - 10'd1;
  end

endmodule

// File: rtl/jump_ctrl.sv
// Branch controller: holds the instruction register, decodes branches and
// halts, and sequences IDLE/RUN/BUBBLE/DONE around the fetch unit.
import jump_pkg::*;

module jump_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [8:0] Inst,
  input  logic       ZeroFlag,
  output logic       FetchHold,
  output logic       Jump,
  output logic       BranchAbsOrRel,
  output logic [9:0] Target,
  output logic       Squash,
  output logic       Done
);

  state_e     state, state_nxt;
  logic       start_seen, start_seen_nxt;
  logic [8:0] ir, ir_nxt;
  logic       ir_valid, ir_valid_nxt;
  cond_e      cond;
  logic       cond_true;
  logic       take;
  logic       halt;
  logic [9:0] lut_target;

  target_lut u_target_lut (
    .Idx    (ir[2:0]),
    .Rel    (ir[5]),
    .Target (lut_target)
  );

  // Decode the branch held in IR and drive the status outputs
  always_comb begin
    cond      = cond_e'(ir[4:3]);
    cond_true = 1'b0;
    unique case (cond)
      COND_ALWAYS: cond_true = 1'b1;
      COND_ZERO:   cond_true = ZeroFlag;
      COND_NZERO:  cond_true = ~ZeroFlag;
      default:     cond_true = 1'b0;
    endcase
    // A Start request overrides both a taken branch and a halt
    take = (state == RUN) && ir_valid && (ir[8:6] == BR_OPCODE) &&
           (cond != COND_HALT) && cond_true && !Start;
    halt = (state == RUN) && ir_valid && (ir[8:6] == BR_OPCODE) &&
           (cond == COND_HALT) && !Start;

    FetchHold      = (state == IDLE) || (state == DONE);
    Squash         = (state == BUBBLE);
    Done           = (state == DONE);
    Jump           = take;
    BranchAbsOrRel = take & ir[5];
    Target         = take ? lut_target : '0;
  end

  // Next-state, IR load and start-handshake tracking
  always_comb begin
    state_nxt      = state;
    start_seen_nxt = start_seen;
    ir_nxt         = ir;
    ir_valid_nxt   = ir_valid;
    unique case (state)
      IDLE: begin
        if (Start) begin
          start_seen_nxt = 1'b1;
        end else if (start_seen) begin
          state_nxt      = RUN;
          start_seen_nxt = 1'b0;
        end
      end
      RUN, BUBBLE: begin
        if (Start) begin
          state_nxt      = IDLE;
          ir_valid_nxt   = 1'b0;
          start_seen_nxt = 1'b1;
        end else begin
          ir_nxt       = Inst;
          ir_valid_nxt = 1'b1;
          if (halt) begin
            state_nxt    = DONE;
            ir_valid_nxt = 1'b0;
          end else if (take) begin
            state_nxt = BUBBLE;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      DONE: begin
        if (Start) begin
          state_nxt      = IDLE;
          start_seen_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and instruction register, asynchronously cleared
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      start_seen <= 1'b0;
      ir         <= '0;
      ir_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_seen <= start_seen_nxt;
      ir         <= ir_nxt;
      ir_valid   <= ir_valid_nxt;
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Randomized self-checking bench for jump_ctrl with a program-level reference model.
module tb_jump_ctrl;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [8:0] Inst;
  logic       ZeroFlag;
  logic       FetchHold;
  logic       Jump;
  logic       BranchAbsOrRel;
  logic [9:0] Target;
  logic       Squash;
  logic       Done;

  jump_ctrl dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Start          (Start),
    .Inst           (Inst),
    .ZeroFlag       (ZeroFlag),
    .FetchHold      (FetchHold),
    .Jump           (Jump),
    .BranchAbsOrRel (BranchAbsOrRel),
    .Target         (Target),
    .Squash         (Squash),
    .Done           (Done)
  );

  // Target table as written in the block's requirements
  int lut_ref [8] = '{3, 512, 100, 1016, 1, 1023, 0, 600};

  logic [8:0] rom [1024];
  logic [9:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: program-level view of the controller
  bit         m_active;
  bit         m_bubble;
  bit         m_halted;
  bit         m_armed;
  bit         m_irv;
  logic [8:0] m_ir;
  int         m_ir_pc;
  int         m_pc;

  bit inject_req;
  bit was_reset;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Fetch unit stand-in: PC advances, holds, or follows the redirect
  always @(posedge Clk or posedge Reset) begin
    if (Reset)               pc <= '0;
    else if (Jump)           pc <= BranchAbsOrRel ? pc + Target : Target;
    else if (!FetchHold)     pc <= pc + 10'd1;
  end

  assign Inst = rom[pc];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_bubble = 0; m_halted = 0; m_armed = 0;
    m_irv = 0; m_ir = '0; m_ir_pc = 0; m_pc = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_fetchhold"}, 32'(FetchHold), 32'd1);
    check_eq({tag, "_jump"}, 32'(Jump), 32'd0);
    check_eq({tag, "_absrel"}, 32'(BranchAbsOrRel), 32'd0);
    check_eq({tag, "_target"}, 32'(Target), 32'd0);
    check_eq({tag, "_squash"}, 32'(Squash), 32'd0);
    check_eq({tag, "_done"}, 32'(Done), 32'd0);
    check_eq({tag, "_pc"}, 32'(pc), 32'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    check_reset_outputs("reset");
    Reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model
  task automatic step(input bit start_v);
    logic [8:0] inst;
    bit br, ctrue, running, e_jump, e_halt, rel;
    int cnd, off, dest, e_tgt;
    @(negedge Clk);
    Start    = start_v;
    ZeroFlag = 1'($urandom_range(0, 1));
    #1;
    br      = m_irv && (m_ir[8:6] == 3'b111);
    cnd     = int'(m_ir[4:3]);
    rel     = m_ir[5];
    off     = lut_ref[m_ir[2:0]];
    ctrue   = (cnd == 0) || (cnd == 1 && ZeroFlag) || (cnd == 2 && !ZeroFlag);
    running = m_active && !m_bubble;
    e_jump  = running && br && cnd != 3 && ctrue && !start_v;
    e_halt  = running && br && cnd == 3 && !start_v;
    // Destination measured from the branch's own address
    dest    = rel ? (m_ir_pc + off) % 1024 : off;
    // Relative addend is whatever takes the current fetch PC to the destination
    e_tgt   = !e_jump ? 0 : (rel ? (dest - m_pc + 1024) % 1024 : dest);

    check_eq("fetch_pc", 32'(pc), 32'(m_pc));
    check_eq("fetchhold", 32'(FetchHold), 32'(!m_active));
    check_eq("squash", 32'(Squash), 32'(m_bubble));
    check_eq("done", 32'(Done), 32'(m_halted));
    check_eq("jump", 32'(Jump), 32'(e_jump));
    check_eq("absrel", 32'(BranchAbsOrRel), 32'(e_jump && rel));
    check_eq("target", 32'(Target), 32'(e_tgt));

    if (e_jump && inject_req) begin
      #1 Reset = 1'b1;
      #1;
      check_reset_outputs("midjump_reset");
      @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      was_reset = 1;
      return;
    end

    inst = rom[m_pc];
    if (m_active) begin
      if (start_v) begin
        m_active = 0; m_bubble = 0; m_irv = 0; m_armed = 1;
        m_pc = (m_pc + 1) % 1024;
      end else if (e_halt) begin
        m_active = 0; m_halted = 1; m_irv = 0;
        m_pc = (m_pc + 1) % 1024;
      end else begin
        m_ir = inst; m_irv = 1; m_ir_pc = m_pc;
        m_bubble = e_jump;
        m_pc = e_jump ? dest : (m_pc + 1) % 1024;
      end
    end else if (m_halted) begin
      if (start_v) begin m_halted = 0; m_armed = 1; end
    end else begin
      if (start_v) m_armed = 1;
      else if (m_armed) begin m_active = 1; m_armed = 0; end
    end
  endtask

  task automatic start_seq();
    repeat (3) step(1'b1);
    step(1'b0);
  endtask

  initial begin
    bit sv;
    Reset = 1'b1; Start = 1'b0; ZeroFlag = 1'b0;
    inject_req = 0; was_reset = 0;
    model_reset();

    // Directed program: relative wrap at PC 5, absolute to 100, conditional, halt
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    rom[5]    = 9'b111_1_00_011;
    rom[1021] = 9'b111_0_00_010;
    rom[100]  = 9'b111_0_01_000;
    rom[101]  = 9'b111_0_11_000;

    for (int ep = 0; ep < 6; ep++) begin
      if (ep > 0) begin
        for (int i = 0; i < 1024; i++) begin
          if ($urandom_range(0, 2) == 0) rom[i] = {3'b111, 6'($urandom)};
          else                           rom[i] = 9'($urandom);
        end
      end
      do_reset();
      start_seq();
      for (int c = 0; c < 400; c++) begin
        if (m_halted) sv = ($urandom_range(0, 9) == 0);
        else          sv = (ep > 0) && ($urandom_range(0, 59) == 0);
        inject_req = (ep >= 2) && ($urandom_range(0, 5) == 0);
        step(sv);
        if (was_reset) begin
          was_reset = 0;
          inject_req = 0;
          start_seq();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
REQ-001 Clk  input  1  sole clock; all state changes on posedge only.
REQ-002 Reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-003 Start  input  1  program-start request; held high, then released to begin the program.
REQ-004 Inst  input  9  instruction at the current fetch PC, from instruction ROM, combinational.
REQ-005 ZeroFlag  input  1  ALU zero flag, sampled in the cycle a branch decodes.
REQ-006 FetchHold  output  1  drives the fetch unit's Start; 1 = PC holds.
REQ-007 Jump  output  1  branch taken this cycle; PC redirects on the next edge.
REQ-008 BranchAbsOrRel  output  1  0 = absolute Target; 1 = Target is added to the fetch PC.
REQ-009 Target  output  10  absolute address, or wrapped relative addend.
REQ-010 Squash  output  1  the instruction in IR is wrong-path; downstream treats it as a no-op.
REQ-011 Done  output  1  program halted; level output, held until the next Start.

Function
REQ-012 IR register: in RUN, IR <= Inst and IrValid <= 1 every cycle; Jump and Target decode from IR only, never directly from Inst.
REQ-013 Branch format: IR[8:6]=3'b111 is a branch. IR[5]=abs(0)/rel(1). IR[4:3]=cond: 00 always, 01 if ZeroFlag=1, 10 if ZeroFlag=0, 11 halt. IR[2:0]=LUT index.
REQ-014 Jump=1 only when state=RUN, IrValid=1, IR is a branch, cond is not 11, and the condition is true; otherwise Jump=0.
REQ-015 Absolute: Target=LUT[idx], BranchAbsOrRel=0.
REQ-016 Relative: LUT[idx] is a 10-bit two's-complement offset from the branch PC. The fetch PC is already branch PC+1, so Target=(LUT[idx]-1) mod 1024 and BranchAbsOrRel=1. All arithmetic is 10-bit and wraps with no saturation.
REQ-017 When Jump=0, Target=0 and BranchAbsOrRel=0.
REQ-018 States:
- IDLE: FetchHold=1.
- RUN: FetchHold=0.
- BUBBLE: FetchHold=0, Squash=1.
- DONE: FetchHold=1, Done=1.
REQ-019 IDLE->RUN on the first edge where Start=0 after StartSeen=1; StartSeen sets on any edge in IDLE or DONE with Start=1.
REQ-020 RUN->BUBBLE on an edge where Jump=1. In BUBBLE, IR still loads, but the loaded instruction is squashed; BUBBLE->RUN after exactly 1 cycle.
REQ-021 RUN->DONE on an edge where IrValid=1 and IR is a branch with cond=11; IrValid clears on entry to DONE.
REQ-022 DONE->IDLE on an edge with Start=1, with StartSeen set.
REQ-023 Start=1 in RUN or BUBBLE: go to IDLE, clear IrValid, set StartSeen. Start takes priority over a simultaneous taken branch or halt, so Jump is forced to 0 in that cycle.
REQ-024 Branch decoded in BUBBLE: it is squashed and never taken; back-to-back branches cost 2 cycles each.
REQ-025 Squash=1 only in BUBBLE; Done=1 only in DONE.

Reset
REQ-026 Reset asserted (asynchronous) puts the block in this state:
- State=IDLE, StartSeen=0, IR=0, IrValid=0.
- Outputs: FetchHold=1, Jump=0, BranchAbsOrRel=0, Target=0, Squash=0, Done=0.
REQ-027 Reset mid-branch: Jump drops the same cycle with no clock needed; the pending redirect is lost.
REQ-028 After Reset deasserts, the block needs a full Start high/low sequence before leaving IDLE.

Structure
REQ-029 Package jump_pkg contains:
- the state enum {IDLE, RUN, BUBBLE, DONE};
- the branch opcode constant 3'b111;
- the cond enum;
- the 8-entry, 10-bit LUT constant array.
REQ-030 A single sub-module, target_lut, is combinational: index and abs/rel in, Target out, including the -1 relative correction.
REQ-031 The state machine and IR live in jump_ctrl; no other sub-modules.

Verification
REQ-032 Start: Reset, Start=1 for 3 cycles then 0 -> FetchHold falls 1 cycle after Start falls; the state goes to RUN.
REQ-033 Absolute branch: IR=9'b111_0_00_010 with LUT[2]=10'd100 -> Jump=1, BranchAbsOrRel=0, Target=100; the next cycle has Squash=1; the fetch PC reaches 100.
REQ-034 Relative branch with wrap: branch at PC 5, LUT[idx]=-8 (10'h3F8) -> Target=10'h3F7; the fetch PC reaches 1021.
REQ-035 Conditional branch, cond=01:
- ZeroFlag=0 -> Jump=0, no bubble.
- ZeroFlag=1 -> Jump=1.
REQ-036 Halt and priority:
- cond=11 -> Done=1, FetchHold=1 the next cycle; a later Start pulse returns to IDLE.
- Start=1 in the same cycle as a taken branch -> Jump=0, state IDLE.
REQ-037 Asynchronous reset while Jump=1 -> all outputs reach reset values before the next posedge.
